// File: rtl/rggen_axi4lite_bridge_if.sv
// +----------------------------------------------------------------------+
// | rggen_axi4lite_if : AXI4-Lite channel bundle with master/slave views  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface rggen_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [1:0]                rresp;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );
endinterface

`default_nettype wire

// File: rtl/rggen_axi4lite_bridge.sv
// +----------------------------------------------------------------------+
// | rggen_axi4lite_bridge : AXI4-Lite slave to single-beat register bus  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rggen_axi4lite_bridge #(
  parameter int    ADDRESS_WIDTH  = 16,
  parameter int    DATA_WIDTH     = 32,
  parameter string ARBITRATION    = "ROUND_ROBIN",
  parameter int    ACCESS_TIMEOUT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  rggen_axi4lite_if.slave           axi4lite_if,
  output logic                      register_valid,
  output logic                      register_write,
  output logic [ADDRESS_WIDTH-1:0]  register_address,
  output logic [DATA_WIDTH-1:0]     register_write_data,
  output logic [DATA_WIDTH/8-1:0]   register_strobe,
  input  logic                      register_ready,
  input  logic [1:0]                register_status,
  input  logic [DATA_WIDTH-1:0]     register_read_data
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int TW         = (ACCESS_TIMEOUT > 0) ? $clog2(ACCESS_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST =
    TW'((ACCESS_TIMEOUT > 0) ? ACCESS_TIMEOUT - 1 : 0);
  localparam logic [ADDRESS_WIDTH-1:0] LSB_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam bit ARB_WF = (ARBITRATION == "WRITE_FIRST");
  localparam bit ARB_RF = (ARBITRATION == "READ_FIRST");
  localparam bit ARB_RR = (ARBITRATION == "ROUND_ROBIN");

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("rggen_axi4lite_bridge: DATA_WIDTH must be 32 or 64");
    end
    if (!(ARB_WF || ARB_RF || ARB_RR)) begin : g_bad_arbitration
      $error("rggen_axi4lite_bridge: unknown ARBITRATION mode");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE            = 2'd0,
    ST_ACCESS          = 2'd1,
    ST_WRITE_RESPONSE  = 2'd2,
    ST_READ_RESPONSE   = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     aw_held_q, w_held_q, ar_held_q;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]    w_data_q;
  logic [STRB_WIDTH-1:0]    w_strb_q;
  logic                     last_write_q;
  logic [TW-1:0]            timer_q;
  logic                     reg_valid_q, reg_write_q;
  logic [ADDRESS_WIDTH-1:0] reg_addr_q;
  logic [DATA_WIDTH-1:0]    reg_wdata_q;
  logic [STRB_WIDTH-1:0]    reg_strb_q;
  logic                     bvalid_q, rvalid_q;
  logic [1:0]               bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  logic       w_write_pend, w_read_pend, w_contested, w_grant_write;
  logic       w_b_done, w_r_done, w_timeout;
  logic [1:0] w_resp;

  assign w_write_pend  = aw_held_q & w_held_q;
  assign w_read_pend   = ar_held_q;
  assign w_contested   = w_write_pend & w_read_pend;
  // Round robin alternates on contested grants only; the register starts at "read".
  assign w_grant_write = w_write_pend &
                         (!w_read_pend || ARB_WF || (ARB_RR && !last_write_q));
  assign w_b_done      = (state_q == ST_WRITE_RESPONSE) && axi4lite_if.bready;
  assign w_r_done      = (state_q == ST_READ_RESPONSE) && axi4lite_if.rready;
  assign w_timeout     = (ACCESS_TIMEOUT > 0) && (timer_q == TIMEOUT_LAST);
  assign w_resp        = (register_ready && !register_status[1]) ? 2'b00 : 2'b10;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (axi4lite_if.awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= axi4lite_if.awaddr;
      end else if (w_b_done) begin
        aw_held_q <= 1'b0;
      end
      if (axi4lite_if.wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        w_data_q <= axi4lite_if.wdata;
        w_strb_q <= axi4lite_if.wstrb;
      end else if (w_b_done) begin
        w_held_q <= 1'b0;
      end
      if (axi4lite_if.arvalid && !ar_held_q) begin
        ar_held_q <= 1'b1;
        ar_addr_q <= axi4lite_if.araddr;
      end else if (w_r_done) begin
        ar_held_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_write_q <= 1'b0;
      timer_q      <= '0;
      reg_valid_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_strb_q   <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      rresp_q      <= 2'b00;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_write_pend || w_read_pend) begin
            state_q     <= ST_ACCESS;
            timer_q     <= '0;
            reg_valid_q <= 1'b1;
            reg_write_q <= w_grant_write;
            if (w_contested) begin
              last_write_q <= w_grant_write;
            end
            if (w_grant_write) begin
              reg_addr_q  <= aw_addr_q & ~LSB_MASK;
              reg_wdata_q <= w_data_q;
              reg_strb_q  <= w_strb_q;
            end else begin
              reg_addr_q  <= ar_addr_q & ~LSB_MASK;
              reg_wdata_q <= '0;
              reg_strb_q  <= '1;
            end
          end
        end
        ST_ACCESS: begin
          if (register_ready || w_timeout) begin
            reg_valid_q <= 1'b0;
            if (reg_write_q) begin
              state_q  <= ST_WRITE_RESPONSE;
              bvalid_q <= 1'b1;
              bresp_q  <= w_resp;
            end else begin
              state_q  <= ST_READ_RESPONSE;
              rvalid_q <= 1'b1;
              rresp_q  <= w_resp;
              rdata_q  <= register_ready ? register_read_data : '0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_WRITE_RESPONSE: begin
          if (axi4lite_if.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_READ_RESPONSE: begin
          if (axi4lite_if.rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi4lite_if.awready = !aw_held_q;
  assign axi4lite_if.wready  = !w_held_q;
  assign axi4lite_if.arready = !ar_held_q;
  assign axi4lite_if.bvalid  = bvalid_q;
  assign axi4lite_if.bresp   = bresp_q;
  assign axi4lite_if.rvalid  = rvalid_q;
  assign axi4lite_if.rresp   = rresp_q;
  assign axi4lite_if.rdata   = rdata_q;

  assign register_valid      = reg_valid_q;
  assign register_write      = reg_write_q;
  assign register_address    = reg_addr_q;
  assign register_write_data = reg_wdata_q;
  assign register_strobe     = reg_strb_q;
endmodule

`default_nettype wire
